// File: rtl/reg_desp_pkg.sv
// Shared mode encodings and FSM state type for the parametrised universal shift register.
package reg_desp_pkg;

   localparam logic [2:0] MODO_HOLD  = 3'b000;
   localparam logic [2:0] MODO_LOAD  = 3'b001;
   localparam logic [2:0] MODO_SHIFT = 3'b010;
   localparam logic [2:0] MODO_ROT   = 3'b011;
   localparam logic [2:0] MODO_SHN   = 3'b100;
   localparam logic [2:0] MODO_ROTN  = 3'b101;
   localparam logic [2:0] MODO_ASHR  = 3'b110;
   localparam logic [2:0] MODO_BURST = 3'b111;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/reg_desp_if.sv
// Control/data bundle of the shift register; master drives commands, slave returns state.
interface reg_desp_if #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
);

   logic             enb;
   logic             dir;
   logic             sIn;
   logic [2:0]       modo;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] D;
   logic             start;
   logic [WIDTH-1:0] Q;
   logic             sOut;
   logic             busy;
   logic             done;

   modport master (
      output enb, dir, sIn, modo, shamt, D, start,
      input  Q, sOut, busy, done
   );

   modport slave (
      input  enb, dir, sIn, modo, shamt, D, start,
      output Q, sOut, busy, done
   );

endinterface

// File: rtl/reg_desp_shifter.sv
// Purely combinational next-Q for the shift/rotate modes; other modes pass Q through.
module reg_desp_shifter
   import reg_desp_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_dir,
   input  logic             i_sin,
   input  logic [SHW-1:0]   i_shamt,
   input  logic [2:0]       i_modo,
   output logic [WIDTH-1:0] o_q
);

   logic [2*WIDTH-1:0] w_dbl_l;
   logic [2*WIDTH-1:0] w_dbl_r;

   // Rotating the doubled word avoids a WIDTH-shamt term that breaks at shamt=0.
   assign w_dbl_l = {i_q, i_q} << i_shamt;
   assign w_dbl_r = {i_q, i_q} >> i_shamt;

   // NOTE: o_q gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      o_q = i_q;
      case (i_modo)
         MODO_SHIFT: o_q = i_dir ? {i_sin, i_q[WIDTH-1:1]} : {i_q[WIDTH-2:0], i_sin};
         MODO_ROT:   o_q = i_dir ? {i_q[0], i_q[WIDTH-1:1]} : {i_q[WIDTH-2:0], i_q[WIDTH-1]};
         MODO_SHN:   o_q = i_dir ? (i_q >> i_shamt) : (i_q << i_shamt);
         MODO_ROTN:  o_q = i_dir ? w_dbl_r[WIDTH-1:0] : w_dbl_l[2*WIDTH-1:WIDTH];
         MODO_ASHR:  o_q = WIDTH'($signed(i_q) >>> i_shamt);
         default:    o_q = i_q;
      endcase
   end

endmodule

// File: rtl/reg_desp_param.sv
// Universal shift register with hold/load/shift/rotate modes and a self-timed WIDTH-bit serial burst.
module reg_desp_param
   import reg_desp_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   reg_desp_if.slave  bus
);

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic [SHW:0]     r_cnt;
   logic             r_busy;
   logic             r_done;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic [SHW:0]     w_cnt_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic [2:0]       w_shift_modo;
   logic [WIDTH-1:0] w_shift_q;

   // A running burst always does a plain 1-bit shift, whatever modo says.
   assign w_shift_modo = (r_state == RUN) ? MODO_SHIFT : bus.modo;

   reg_desp_shifter #(.WIDTH(WIDTH)) u_shifter (
      .i_q     (r_q),
      .i_dir   (bus.dir),
      .i_sin   (bus.sIn),
      .i_shamt (bus.shamt),
      .i_modo  (w_shift_modo),
      .o_q     (w_shift_q)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_cnt_nxt   = r_cnt;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      if (bus.enb) begin
         case (r_state)
            IDLE: begin
               case (bus.modo)
                  MODO_LOAD: w_q_nxt = bus.D;
                  MODO_SHIFT, MODO_ROT, MODO_SHN, MODO_ROTN, MODO_ASHR: w_q_nxt = w_shift_q;
                  MODO_BURST: begin
                     if (bus.start) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = (SHW+1)'(WIDTH);
                        w_busy_nxt  = 1'b1;
                     end
                  end
                  default: w_q_nxt = r_q;
               endcase
            end
            RUN: begin
               w_q_nxt   = w_shift_q;
               w_cnt_nxt = r_cnt - (SHW+1)'(1);
               if (r_cnt == (SHW+1)'(1)) begin
                  w_state_nxt = IDLE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_q     <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign bus.Q    = r_q;
   assign bus.sOut = bus.dir ? r_q[0] : r_q[WIDTH-1];
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule
